lz4_shifter_fetch_ctrl: RTL
===========================

# lz4_shifter_fetch_ctrl

Sequencing controller for the LZ4 shifter's input path. It issues read requests to the 32-bit prefetch stage and counts the words of one compression block. It packs accepted words into an 8-byte window and lets the shifter consume 1–4 bytes per cycle. It also flags the last three words of the block and signals completion once every byte, including a partial final word, has been consumed.

## Interface
Parameters:
- WCNT_W, 16, width of the block word counter; maximum block is 2^WCNT_W−1 words.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a block; sampled only in IDLE.
- total_words  in  WCNT_W  number of 32-bit words in the block; sampled with start.
- tail_bytes  in  2  valid bytes in the final word; 0 means 4; sampled with start.
- pref_rd  out  1  read request to the prefetch stage.
- pref_data  in  32  prefetch word; byte 0 is [7:0].
- pref_valid  in  1  prefetch word valid.
- last_3dwords  out  1  high while in RUN with 1 ≤ words_left ≤ 3.
- win_data  out  32  lowest 4 window bytes; window byte 0 is on [7:0].
- win_bytes  out  4  valid bytes in the window, 0..8.
- consume  in  1  shifter takes consume_len bytes this cycle.
- consume_len  in  3  1..4.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at block end.
- err  out  1  sticky illegal-consume flag; cleared by start or rst.

## Operation
State machine: IDLE, RUN, DRAIN.
- IDLE, start=1:
  - words_left ← total_words, tail latched, err ← 0.
  - If total_words=0: done=1 next cycle and stay in IDLE.
  - Otherwise go to RUN.
- IDLE, start=0: no action.
- RUN:
  - pref_rd = (words_left≠0) & (win_bytes≤4). This is combinational from registered state only.
  - A word is accepted when pref_rd & pref_valid in the same cycle.
  - On accept, words_left decrements.
  - If the accepted word made words_left reach 0, go to DRAIN.
- DRAIN:
  - pref_rd=0.
  - When win_bytes reaches 0, pulse done and return to IDLE.
- start while busy is ignored.

Window update each cycle:
- Let c = consume_len if the consume is legal, else 0. Let a = bytes appended.
  - a = 4 on accept.
  - a = tail bytes when the accepted word is the final word (tail_bytes=0 counts as 4).
  - a = 0 otherwise.
- win_bytes_next = win_bytes − c + a.
- The window shifts down by c bytes.
- The accepted bytes are placed at byte position win_bytes − c.
- Unused bytes of the final word are discarded.
- Bytes above win_bytes read 0.

Consume rules:
- Legal iff consume=1, 1≤consume_len≤4, and consume_len≤win_bytes.
- An illegal consume is ignored entirely (no shift) and sets err. err is only set while busy.
- A consume in IDLE is ignored and does not set err.

Arithmetic:
- words_left is unsigned WCNT_W and never wraps below 0.
- The window count cannot exceed 8, because appends happen only when win_bytes≤4.

## Timing
- Reset values: pref_rd=0, last_3dwords=0, win_data=0, win_bytes=0, busy=0, done=0, err=0, state=IDLE, words_left=0.
- Reset mid-block aborts immediately; no done is issued.
- start in cycle 0 gives busy=1 and pref_rd=1 in cycle 1, provided total_words>0.
- An accept in cycle t is visible on win_bytes/win_data in cycle t+1.
- Steady state with consume_len=4 every cycle and pref_valid always high sustains 4 bytes/cycle (win_bytes stays 4).
- If pref_valid stays low, pref_rd stays high and waits; there is no timeout.
- done is asserted the cycle after the cycle in which win_bytes becomes 0 in DRAIN, then the block returns to IDLE.
  - Exception: total_words=0, where done follows start by one cycle.
- A consume and an accept in the same cycle are both applied, as in the formula above.

## Test plan
- Reset check: assert rst mid-RUN with win_bytes=6 → all outputs 0 within the same cycle; after rst is released no done, and state is IDLE.
- Throughput: total_words=4, tail_bytes=0, data 0x03020100, 0x07060504, …, consume_len=4 each cycle once win_bytes≥4 → win_data sequence 0x03020100, 0x07060504, …, 16 bytes total; done 1 cycle after win_bytes hits 0; last_3dwords high while words_left is 3, 2 or 1.
- Partial tail: total_words=2, tail_bytes=1, words 0x44332211 and 0xDDCCBBAA, no consume → win_bytes=5, win_data=0x44332211; then consume_len=4 → win_bytes=1, win_data=0x000000AA; then consume_len=1 → done.
- Backpressure: consume=0 with pref_valid high → pref_rd drops once win_bytes=8; after consume_len=4, pref_rd resumes the next cycle.
- Illegal consume: win_bytes=2, consume_len=3 → window unchanged, err=1 sticky; next start clears err.
- Edge starts: total_words=0 → done pulses 1 cycle after start and busy stays 0. start during RUN → ignored, and words_left is unaffected.

Source files
------------

// File: rtl/lz4_shifter_fetch_ctrl.sv
// LZ4 shifter fetch controller: requests prefetch words for one block, packs
// them into an 8-byte window, lets the shifter consume 1-4 bytes per cycle,
// and signals block completion once the window is fully drained.
module lz4_shifter_fetch_ctrl #(
    parameter int unsigned WCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WCNT_W-1:0] total_words,
    input  logic [1:0]        tail_bytes,
    output logic              pref_rd,
    input  logic [31:0]       pref_data,
    input  logic              pref_valid,
    output logic              last_3dwords,
    output logic [31:0]       win_data,
    output logic [3:0]        win_bytes,
    input  logic              consume,
    input  logic [2:0]        consume_len,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [WCNT_W-1:0] words_left;
    logic [1:0]        tail;
    logic [63:0]       win;

    logic              accept;
    logic              final_word;
    logic [2:0]        app_len;
    logic              legal;
    logic              illegal;
    logic [2:0]        cut_len;
    logic [31:0]       byte_mask;
    logic [3:0]        ins_pos;
    logic [63:0]       win_nxt;
    logic [3:0]        wb_nxt;

    // Status decode from registered state only
    always_comb begin
        busy         = (state != IDLE);
        pref_rd      = (state == RUN) && (words_left != '0) && (win_bytes <= 4'd4);
        last_3dwords = (state == RUN) && (words_left != '0) && (words_left <= WCNT_W'(3));
        win_data     = win[31:0];
    end

    // Window next-state: drop consumed bytes, append accepted bytes on top
    always_comb begin
        accept     = pref_rd & pref_valid;
        final_word = accept && (words_left == WCNT_W'(1));

        app_len = 3'd0;
        if (accept) begin
            if (final_word && (tail != 2'd0)) begin
                app_len = {1'b0, tail};
            end else begin
                app_len = 3'd4;
            end
        end

        legal   = busy && consume && (consume_len != 3'd0) && (consume_len <= 3'd4)
                  && ({1'b0, consume_len} <= win_bytes);
        illegal = busy && consume && !legal;
        cut_len = legal ? consume_len : 3'd0;

        case (app_len)
            3'd1:    byte_mask = 32'h0000_00FF;
            3'd2:    byte_mask = 32'h0000_FFFF;
            3'd3:    byte_mask = 32'h00FF_FFFF;
            3'd4:    byte_mask = 32'hFFFF_FFFF;
            default: byte_mask = 32'h0000_0000;
        endcase

        ins_pos = win_bytes - {1'b0, cut_len};
        win_nxt = (win >> {cut_len, 3'b000})
                | ({32'h0, pref_data & byte_mask} << {ins_pos, 3'b000});
        wb_nxt  = ins_pos + {1'b0, app_len};
    end

    // Control FSM, word counter, window and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            words_left <= '0;
            tail       <= 2'd0;
            win        <= 64'h0;
            win_bytes  <= 4'd0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done      <= 1'b0;
            win       <= win_nxt;
            win_bytes <= wb_nxt;
            if (illegal) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        words_left <= total_words;
                        tail       <= tail_bytes;
                        err        <= 1'b0;
                        if (total_words == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        words_left <= words_left - WCNT_W'(1);
                        if (final_word) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (win_bytes == 4'd0) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
